serial_paralelo_sync: RTL and testbench

SERIAL_PARALELO_SYNC -- requirements
Module: serial_paralelo_sync

---
 rtl/serial_paralelo_pkg.sv | 18 +
 rtl/serial_paralelo_sync_detector_comma.sv | 33 +++
 rtl/serial_paralelo_sync.sv | 151 +++++++++++++++
 tb/tb_serial_paralelo_sync.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_paralelo_pkg.sv
// Shared types and constants for the serial-to-parallel comma aligner.
// Optional loss-of-lock logic in the top level is enabled by LOSS_OF_LOCK_EN.
package serial_paralelo_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

  // Bits needed to hold any value in 0..max_value (at least one bit).
  function automatic int cnt_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/serial_paralelo_sync_detector_comma.sv
// Serial shift register and comma comparator: presents the word ending with
// the current bit as candidate and flags when it equals COMMA.
module detector_comma
  import serial_paralelo_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] COMMA = WIDTH'(COMMA_DEFAULT)
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] candidate,
  output logic             match
);

  // The oldest bit of a full WIDTH-bit register would never be read, because
  // the candidate already includes the bit arriving this cycle.
  logic [WIDTH-2:0] shift_q;

  assign candidate = {shift_q, data_in};
  assign match     = (candidate == COMMA);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement or block order.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
    end else begin
      shift_q <= candidate[WIDTH-2:0];
    end
  end

endmodule

// File: rtl/serial_paralelo_sync.sv
// Serial-to-parallel converter that locks onto a repeated comma symbol and
// emits non-comma words. Define LOSS_OF_LOCK_EN to drop lock after MAX_GAP
// words without a comma; otherwise only reset leaves ACTIVE.
module serial_paralelo_sync
  import serial_paralelo_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(COMMA_DEFAULT),
  parameter int               LOCK_COUNT = 4,
  parameter int               MAX_GAP    = 16
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active
);

  localparam int BIT_W = cnt_width(WIDTH - 1);
  // One width serves both the comma count and the optional gap count.
  localparam int CNT_W = cnt_width((LOCK_COUNT > MAX_GAP) ? LOCK_COUNT : MAX_GAP);

  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LOCK_TARGET = CNT_W'(LOCK_COUNT);

  logic [WIDTH-1:0] candidate;
  logic             match;

  detector_comma #(
    .WIDTH (WIDTH),
    .COMMA (COMMA)
  ) u_detector (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .candidate (candidate),
    .match     (match)
  );

  state_e           state_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] comma_cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             active_q;

  logic             boundary;
  logic [CNT_W-1:0] comma_inc;

  assign boundary  = (bit_cnt_q == LAST_BIT);
  assign comma_inc = comma_cnt_q + CNT_W'(1);

`ifdef LOSS_OF_LOCK_EN
  localparam logic [CNT_W-1:0] GAP_LIMIT = CNT_W'(MAX_GAP);

  logic [CNT_W-1:0] gap_cnt_q;
  logic [CNT_W-1:0] gap_inc;

  assign gap_inc = gap_cnt_q + CNT_W'(1);
`endif

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SEARCH;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
`ifdef LOSS_OF_LOCK_EN
      gap_cnt_q   <= '0;
`endif
    end else begin
      valid_q   <= 1'b0;
      bit_cnt_q <= boundary ? '0 : bit_cnt_q + BIT_W'(1);

      unique case (state_q)
        ST_SEARCH: begin
          // A comma seen at any bit offset fixes the word phase.
          if (match) begin
            bit_cnt_q   <= '0;
            comma_cnt_q <= CNT_W'(1);
            if (LOCK_COUNT == 1) begin
              state_q  <= ST_ACTIVE;
              active_q <= 1'b1;
`ifdef LOSS_OF_LOCK_EN
              gap_cnt_q <= '0;
`endif
            end else begin
              state_q <= ST_ALIGN;
            end
          end
        end

        ST_ALIGN: begin
          if (boundary) begin
            if (match) begin
              comma_cnt_q <= comma_inc;
              if (comma_inc == LOCK_TARGET) begin
                state_q  <= ST_ACTIVE;
                active_q <= 1'b1;
`ifdef LOSS_OF_LOCK_EN
                gap_cnt_q <= '0;
`endif
              end
            end else begin
              state_q     <= ST_SEARCH;
              comma_cnt_q <= '0;
            end
          end
        end

        ST_ACTIVE: begin
          if (boundary && !match) begin
`ifdef LOSS_OF_LOCK_EN
            if (gap_inc >= GAP_LIMIT) begin
              state_q     <= ST_SEARCH;
              active_q    <= 1'b0;
              comma_cnt_q <= '0;
              gap_cnt_q   <= '0;
            end else begin
              data_q    <= candidate;
              valid_q   <= 1'b1;
              gap_cnt_q <= gap_inc;
            end
`else
            data_q  <= candidate;
            valid_q <= 1'b1;
`endif
          end
`ifdef LOSS_OF_LOCK_EN
          if (boundary && match) begin
            gap_cnt_q <= '0;
          end
`endif
        end

        default: begin
          state_q  <= ST_SEARCH;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// Self-checking bench: three aligner instances (default, MAX_GAP=2, 10-bit)
// checked every cycle against a word-level model plus literal expectations.
module tb_serial_paralelo_sync;

  localparam int NI = 3;
  localparam int M_SEARCH = 0;
  localparam int M_ALIGN  = 1;
  localparam int M_ACTIVE = 2;
`ifdef LOSS_OF_LOCK_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic [2:0] din     = '0;

  wire  [7:0] dout0;
  wire  [7:0] dout1;
  wire  [9:0] dout2;
  wire  [2:0] vld;
  wire  [2:0] act;

  always #5 clk_32f = ~clk_32f;

  serial_paralelo_sync u_dut0 (
    .clk_32f (clk_32f), .reset (reset), .data_in (din[0]),
    .data_out (dout0), .valid_out (vld[0]), .active (act[0])
  );

  serial_paralelo_sync #(.MAX_GAP(2)) u_dut1 (
    .clk_32f (clk_32f), .reset (reset), .data_in (din[1]),
    .data_out (dout1), .valid_out (vld[1]), .active (act[1])
  );

  serial_paralelo_sync #(.WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(2)) u_dut2 (
    .clk_32f (clk_32f), .reset (reset), .data_in (din[2]),
    .data_out (dout2), .valid_out (vld[2]), .active (act[2])
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act_v, exp_v, $time);
    end
  endtask

  // Word-level model: bits since the last word boundary, a sliding window of
  // the most recent bits, and the comma/gap tallies for each instance.
  int m_w       [NI] = '{8, 8, 10};
  int m_comma   [NI] = '{'hBC, 'hBC, 'h17C};
  int m_lock    [NI] = '{4, 4, 2};
  int m_max_gap [NI] = '{16, 2, 16};
  int m_win     [NI];
  int m_pos     [NI];
  int m_mode    [NI];
  int m_commas  [NI];
  int m_gap     [NI];
  int m_data    [NI];
  bit m_valid   [NI];
  int vcount    [NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_win[i] = 0; m_pos[i] = 0; m_mode[i] = M_SEARCH; m_commas[i] = 0;
      m_gap[i] = 0; m_data[i] = 0; m_valid[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input bit b);
    m_win[i]   = ((m_win[i] << 1) | int'(b)) & ((1 << m_w[i]) - 1);
    m_valid[i] = 1'b0;
    if (m_mode[i] == M_SEARCH) begin
      if (m_win[i] == m_comma[i]) begin
        m_pos[i] = 0; m_commas[i] = 1; m_gap[i] = 0;
        m_mode[i] = (m_lock[i] == 1) ? M_ACTIVE : M_ALIGN;
      end
      return;
    end
    m_pos[i]++;
    if (m_pos[i] < m_w[i]) return;
    m_pos[i] = 0;
    if (m_mode[i] == M_ALIGN) begin
      if (m_win[i] == m_comma[i]) begin
        m_commas[i]++;
        if (m_commas[i] == m_lock[i]) m_mode[i] = M_ACTIVE;
      end else begin
        m_commas[i] = 0;
        m_mode[i]   = M_SEARCH;
      end
    end else if (m_win[i] == m_comma[i]) begin
      m_gap[i] = 0;
    end else begin
      m_gap[i]++;
      if (GAP_EN && m_gap[i] >= m_max_gap[i]) begin
        m_mode[i] = M_SEARCH;
      end else begin
        m_data[i]  = m_win[i];
        m_valid[i] = 1'b1;
      end
    end
  endtask

  bit checking = 1'b0;

  always @(posedge reset) model_reset();

  always @(posedge clk_32f) begin
    if (!reset) begin
      for (int i = 0; i < NI; i++) model_step(i, din[i]);
    end
    #1;
    if (checking) begin
      check("cyc dut0 data_out",  dout0,  m_data[0]);
      check("cyc dut0 valid_out", vld[0], m_valid[0]);
      check("cyc dut0 active",    act[0], m_mode[0] == M_ACTIVE);
      check("cyc dut1 data_out",  dout1,  m_data[1]);
      check("cyc dut1 valid_out", vld[1], m_valid[1]);
      check("cyc dut1 active",    act[1], m_mode[1] == M_ACTIVE);
      check("cyc dut2 data_out",  dout2,  m_data[2]);
      check("cyc dut2 valid_out", vld[2], m_valid[2]);
      check("cyc dut2 active",    act[2], m_mode[2] == M_ACTIVE);
      for (int i = 0; i < NI; i++) if (vld[i]) vcount[i]++;
    end
  end

  // Drive a bit at the falling edge, return just after the edge that samples it.
  task automatic send_bit(input int id, input bit b);
    @(negedge clk_32f);
    din[id] = b;
    @(posedge clk_32f);
    #2;
  endtask

  task automatic send_word(input int id, input logic [31:0] w, input int width);
    for (int k = width - 1; k >= 0; k--) send_bit(id, w[k]);
  endtask

  task automatic send_commas(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      if (id == 2) send_word(id, 32'h17C, 10);
      else         send_word(id, 32'hBC, 8);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    din   = '0;
    reset = 1'b1;
    @(negedge clk_32f);
    reset = 1'b0;
  endtask

  int vc;

  initial begin
    for (int i = 0; i < NI; i++) vcount[i] = 0;
    model_reset();

    // Lock, two data words, then a comma while locked.
    do_reset();
    checking = 1'b1;
    check("reset data_out",  dout0,  8'h00);
    check("reset valid_out", vld[0], 1'b0);
    check("reset active",    act[0], 1'b0);
    send_commas(0, 3);
    check("3 commas active", act[0], 1'b0);
    send_commas(0, 1);
    check("4th comma active", act[0], 1'b1);
    check("4th comma valid",  vld[0], 1'b0);
    send_word(0, 32'hFF, 8);
    check("FF valid", vld[0], 1'b1);
    check("FF data",  dout0,  8'hFF);
    send_word(0, 32'hEE, 8);
    check("EE valid", vld[0], 1'b1);
    check("EE data",  dout0,  8'hEE);
    send_word(0, 32'hBC, 8);
    check("comma in active valid",  vld[0], 1'b0);
    check("comma in active data",   dout0,  8'hEE);
    check("comma in active active", act[0], 1'b1);

    // Three commas then data: no lock, back to SEARCH.
    do_reset();
    vc = vcount[0];
    send_commas(0, 3);
    send_word(0, 32'hFF, 8);
    check("short lock active", act[0], 1'b0);
    check("short lock no valid", vcount[0] - vc, 0);
    send_commas(0, 3);
    check("relock 3 commas active", act[0], 1'b0);
    send_commas(0, 1);
    check("relock 4th comma active", act[0], 1'b1);

    // Three-bit offset ahead of the commas.
    do_reset();
    vc = vcount[0];
    send_bit(0, 1'b1); send_bit(0, 1'b0); send_bit(0, 1'b1);
    send_commas(0, 4);
    check("offset lock active", act[0], 1'b1);
    send_word(0, 32'h5A, 8);
    check("offset 5A valid", vld[0], 1'b1);
    check("offset 5A data",  dout0,  8'h5A);
    check("offset one pulse", vcount[0] - vc, 1);
    send_bit(0, 1'b1);
    check("offset pulse ends", vld[0], 1'b0);

    // Reset in the middle of a word while ACTIVE.
    do_reset();
    send_commas(0, 4);
    send_word(0, 32'hFF, 8);
    check("pre-reset data", dout0, 8'hFF);
    send_bit(0, 1'b1); send_bit(0, 1'b1); send_bit(0, 1'b1); send_bit(0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    check("async reset data_out", dout0,  8'h00);
    check("async reset valid",    vld[0], 1'b0);
    check("async reset active",   act[0], 1'b0);
    @(negedge clk_32f);
    reset = 1'b0;
    vc = vcount[0];
    send_commas(0, 3);
    send_word(0, 32'h33, 8);
    check("post-reset 3 commas active", act[0], 1'b0);
    check("post-reset 3 commas no valid", vcount[0] - vc, 0);
    send_commas(0, 4);
    check("post-reset lock active", act[0], 1'b1);
    send_word(0, 32'h33, 8);
    check("post-reset 33 valid", vld[0], 1'b1);
    check("post-reset 33 data",  dout0,  8'h33);

`ifdef LOSS_OF_LOCK_EN
    // Loss of lock after two comma-free words with MAX_GAP = 2.
    do_reset();
    send_commas(1, 4);
    check("gap lock active", act[1], 1'b1);
    send_word(1, 32'h11, 8);
    check("gap 11 valid", vld[1], 1'b1);
    check("gap 11 data",  dout1,  8'h11);
    send_word(1, 32'h22, 8);
    check("gap 22 valid",  vld[1], 1'b0);
    check("gap 22 active", act[1], 1'b0);
    check("gap 22 data",   dout1,  8'h11);
`endif

    // 10-bit instance, two commas to lock.
    do_reset();
    send_commas(2, 1);
    check("w10 1 comma active", act[2], 1'b0);
    send_commas(2, 1);
    check("w10 2 commas active", act[2], 1'b1);
    send_word(2, 32'h3FF, 10);
    check("w10 3FF valid", vld[2], 1'b1);
    check("w10 3FF data",  dout2,  10'h3FF);

    repeat (4) @(posedge clk_32f);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
